sram_controller: RTL and testbench

Multi-cycle data-memory controller of the MEM stage. It takes the load/store request produced by the EXE stage register, performs the access on an external 16-bit asynchronous SRAM as two half-word transactions, and returns a 32-bit read word to the MEM stage register. While an access is in flight it deasserts `ready`, which the pipeline inverts into the global `freeze`. This holds the PC and every stage register, including the MEM stage register, until the access completes.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_hit_buffer.sv | 40 ++++
 rtl/sram_controller.sv | 142 ++++++++++++++
 tb/tb_sram_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM data-memory controller
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int TAG_W = SRAM_AW - 1;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_hit_buffer.sv
// rtl/sram_hit_buffer.sv - single-entry last-read buffer (used under SRAM_LAST_READ_CACHE_EN)
module sram_hit_buffer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      hit_data,
    input  logic             fill_en,
    input  logic             fill_is_read,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data
);

    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;

    // Completed reads replace the entry; completed writes only refresh a matching entry
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            if (fill_is_read) begin
                valid <= 1'b1;
                tag   <= fill_tag;
                data  <= fill_data;
            end else if (valid && (tag == fill_tag)) begin
                data  <= fill_data;
            end
        end
    end

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage controller for a 16-bit async SRAM; optional SRAM_LAST_READ_CACHE_EN
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             op_write;
    logic [TAG_W-1:0] op_tag;
    logic [31:0]      read_data_q;

    // Only offset bits 18..2 select an SRAM word, so wrap-around falls out of the truncation
    logic [18:0]      offset;
    logic [TAG_W-1:0] word_tag;
    logic             req;
    logic             cache_hit;
    logic [31:0]      hit_data;
    logic             start;
    logic             last_wait;
    logic             unused_bits;

    assign offset      = address[18:0] - BASE_ADDR[18:0];
    assign word_tag    = offset[18:2];
    assign req         = wr_en | rd_en;
    assign last_wait   = (wait_cnt == WAIT_LAST);
    assign unused_bits = &{1'b0, address[31:19], offset[1:0]};

`ifdef SRAM_LAST_READ_CACHE_EN
    logic buf_hit;

    sram_hit_buffer u_hit_buffer (
        .clk          (clk),
        .rst          (rst),
        .lookup_tag   (word_tag),
        .hit          (buf_hit),
        .hit_data     (hit_data),
        .fill_en      (state == ST_DONE),
        .fill_is_read (!op_write),
        .fill_tag     (op_tag),
        .fill_data    (op_write ? write_data : read_data_q)
    );

    // A pure read that hits is answered from the buffer without touching the SRAM
    assign cache_hit = (state == ST_IDLE) && rd_en && !wr_en && buf_hit;
    assign read_data = cache_hit ? hit_data : read_data_q;
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
    assign read_data = read_data_q;
`endif

    assign start = (state == ST_IDLE) && req && !cache_hit;

    // Freeze is released when idle with nothing to do, on a buffer hit, or in the completion cycle
    always_comb begin
        ready = 1'b0;
        if (state == ST_DONE)
            ready = 1'b1;
        else if (state == ST_IDLE && (!req || cache_hit))
            ready = 1'b1;
    end

    // Access sequencer: two half-word phases of WAIT_CYCLES each, pins registered on phase entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            op_write    <= 1'b0;
            op_tag      <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cache_hit)
                        read_data_q <= hit_data;
                    if (start) begin
                        state       <= ST_LOW;
                        wait_cnt    <= '0;
                        op_write    <= wr_en;
                        op_tag      <= word_tag;
                        sram_addr   <= {word_tag, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : '0;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end
                end
                ST_LOW: begin
                    if (last_wait) begin
                        if (!op_write)
                            read_data_q[15:0] <= sram_dq_in;
                        state       <= ST_HIGH;
                        wait_cnt    <= '0;
                        sram_addr   <= {op_tag, 1'b1};
                        sram_dq_out <= op_write ? write_data[31:16] : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_HIGH: begin
                    if (last_wait) begin
                        if (!op_write)
                            read_data_q[31:16] <= sram_dq_in;
                        state      <= ST_DONE;
                        wait_cnt   <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int checks;
    int failures;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:262143] = '{default: 16'h0};
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe)
            mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = mem[sram_addr];

    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] ref_rdata;
    bit          c_valid;
    logic [16:0] c_tag;

    function automatic logic [16:0] tag_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] t);
        return ref_mem.exists(t) ? ref_mem[t] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input string name);
        logic [16:0] t;
        logic [17:0] ea;
        bit          hit;
        int          exp_lat;
        int          lat;
        int          we_low;
        t   = tag_of(a);
        hit = 0;
`ifdef SRAM_LAST_READ_CACHE_EN
        hit = !w && r && c_valid && (c_tag == t);
`endif
        exp_lat = hit ? 0 : 2 * W + 1;
        if (w) begin
            ref_mem[t] = d;
        end else begin
            ref_rdata = ref_read(t);
            c_valid   = 1;
            c_tag     = t;
        end
        lat    = -1;
        we_low = 0;
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (!hit && n >= 1 && n <= 2 * W) begin
                ea = {t, (n > W) ? 1'b1 : 1'b0};
                chk($sformatf("%s addr c%0d", name, n), 32'(sram_addr), 32'(ea));
                chk($sformatf("%s we_n c%0d", name, n), 32'(sram_we_n), 32'(!w));
                chk($sformatf("%s oe c%0d", name, n), 32'(sram_dq_oe), 32'(w));
                if (w)
                    chk($sformatf("%s dq c%0d", name, n), 32'(sram_dq_out),
                        32'((n > W) ? d[31:16] : d[15:0]));
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " we_low"}, 32'(we_low), 32'(w ? 2 * W : 0));
        chk({name, " read_data"}, read_data, exp_rd);
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        int          op;
        int          pc;
        int          we_low;
        logic [16:0] t;

        checks = 0; failures = 0;
        ref_rdata = 0; c_valid = 0; c_tag = 0;
        rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;

        tbl[0] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 32'h00000000};
        tbl[1] = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'd1024,   32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 32'd1024,   32'h0,        32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 32'd1031,   32'h0,        32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b0, 32'd1020,   32'hCAFEF00D, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 1'b1, 32'd525308, 32'h0,        32'hCAFEF00D};
        tbl[7] = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};
        tbl[8] = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset read_data", read_data, 32'h0);
        chk("reset we_n", 32'(sram_we_n), 32'h1);
        chk("reset oe", 32'(sram_dq_oe), 32'h0);
        chk("reset addr", 32'(sram_addr), 32'h0);
        chk("reset dq_out", 32'(sram_dq_out), 32'h0);
        chk("reset ready idle", 32'(ready), 32'h1);
        wr_en = 1;
        #1;
        chk("reset ready with request", 32'(ready), 32'h0);
        wr_en = 0;
        @(posedge clk);
        #1;
        rst = 0;

        for (int i = 0; i < 9; i++)
            access(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_rd, $sformatf("vec%0d", i));

        // back-to-back write then read with freeze = ~ready looped back
        pc = 0; we_low = 0;
        t = tag_of(32'd1100);
        for (int c = 0; c < 16; c++) begin
            wr_en      = (pc == 0);
            rd_en      = (pc == 1);
            address    = (pc < 2) ? 32'd1100 : 32'd0;
            write_data = (pc == 0) ? 32'hA5A55A5A : 32'd0;
            @(negedge clk);
            if (!sram_we_n) we_low++;
            chk($sformatf("b2b ready c%0d", c), 32'(ready), 32'((c == 5) || (c >= 11)));
            if (c == 11) chk("b2b read_data", read_data, 32'hA5A55A5A);
            @(posedge clk);
            if (ready && pc < 2) pc++;
            #1;
        end
        chk("b2b instructions", 32'(pc), 32'd2);
        chk("b2b we_low", 32'(we_low), 32'(2 * W));
        ref_mem[t] = 32'hA5A55A5A;
        ref_rdata  = 32'hA5A55A5A;
        c_valid = 1; c_tag = t;
        wr_en = 0; rd_en = 0;

        // reset in HIGH of a write aborts it
        wr_en = 1; address = 32'd1200; write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        rst = 1; wr_en = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("abort ready", 32'(ready), 32'h1);
        chk("abort we_n", 32'(sram_we_n), 32'h1);
        chk("abort oe", 32'(sram_dq_oe), 32'h0);
        chk("abort read_data", read_data, 32'h0);
        chk("abort addr", 32'(sram_addr), 32'h0);
        @(posedge clk);
        #1;
        ref_rdata = 0; c_valid = 0;
        access(1'b1, 1'b0, 32'd1200, 32'h33334444, 32'h0, "rewrite");

        // randomized traffic against the word-level model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            w  = (op != 1);
            r  = (op != 0);
            a  = BASE + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h80000;
            d  = $urandom;
            access(w, r, a, d, w ? ref_rdata : ref_read(tag_of(a)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
